// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : seq_magnitude_comparator
// Purpose  : Multi-cycle MSB-first digit-serial magnitude comparator with
//            signed/unsigned mode, optional early exit and valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module seq_magnitude_comparator #(
   parameter int WIDTH      = 16,
   parameter int DIGIT      = 2,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_decided;
   logic             r_dec_gt;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;

   logic [DIGIT-1:0] w_da;
   logic [DIGIT-1:0] w_db;
   logic             w_diff;
   logic             w_dgt;
   logic [WIDTH-1:0] w_sign_flip;

   // Flipping the sign bit maps two's complement onto offset binary,
   // so the serial engine only ever performs an unsigned compare.
   assign w_sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

   always_comb begin
      w_da = '0;
      w_db = '0;
      for (int i = 0; i < N; i++) begin
         if (r_cnt == CW'(i)) begin
            w_da = r_a[i*DIGIT +: DIGIT];
            w_db = r_b[i*DIGIT +: DIGIT];
         end
      end
   end

   assign w_diff = (w_da != w_db);
   assign w_dgt  = (w_da > w_db);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_decided <= 1'b0;
         r_dec_gt  <= 1'b0;
         r_gt      <= 1'b0;
         r_eq      <= 1'b0;
         r_lt      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_valid) begin
                  r_a       <= a ^ w_sign_flip;
                  r_b       <= b ^ w_sign_flip;
                  r_cnt     <= CW'(N - 1);
                  r_decided <= 1'b0;
                  r_dec_gt  <= 1'b0;
                  r_state   <= S_RUN;
               end
            end
            S_RUN: begin
               if (EARLY_EXIT && w_diff) begin
                  r_gt    <= w_dgt;
                  r_lt    <= !w_dgt;
                  r_eq    <= 1'b0;
                  r_state <= S_DONE;
               end else if (r_cnt == '0) begin
                  if (r_decided) begin
                     r_gt <= r_dec_gt;
                     r_lt <= !r_dec_gt;
                  end else if (w_diff) begin
                     r_gt <= w_dgt;
                     r_lt <= !w_dgt;
                  end else begin
                     r_eq <= 1'b1;
                  end
                  r_state <= S_DONE;
               end else begin
                  // First difference wins; less significant digits never override it.
                  if (w_diff && !r_decided) begin
                     r_decided <= 1'b1;
                     r_dec_gt  <= w_dgt;
                  end
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  r_gt    <= 1'b0;
                  r_eq    <= 1'b0;
                  r_lt    <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign start_ready = (r_state == S_IDLE);
   assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
   assign res_valid   = (r_state == S_DONE);
   assign gt          = r_gt;
   assign eq          = r_eq;
   assign lt          = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_magnitude_comparator
// Purpose  : Self-checking bench: directed table, corner sequences, random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_magnitude_comparator;

   localparam int W = 16;
   localparam int D = 2;
   localparam int N = W / D;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          sm;
   logic          sv [2];
   logic          rr [2];
   logic          sr [2];
   logic          bz [2];
   logic          rv [2];
   logic          o_g [2];
   logic          o_e [2];
   logic          o_l [2];

   int n_checks;
   int n_fail;

   // Instance 0 exits early, instance 1 always runs all digits.
   seq_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b1)) dut_e (
      .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
      .a(a), .b(b), .signed_mode(sm), .busy(bz[0]), .res_valid(rv[0]),
      .res_ready(rr[0]), .gt(o_g[0]), .eq(o_e[0]), .lt(o_l[0])
   );

   seq_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b0)) dut_f (
      .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
      .a(a), .b(b), .signed_mode(sm), .busy(bz[1]), .res_valid(rv[1]),
      .res_ready(rr[1]), .gt(o_g[1]), .eq(o_e[1]), .lt(o_l[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sm;
      int           w;
      int           lat;
      logic [2:0]   gel;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: arithmetic compare plus first differing digit counted from the MSB.
   task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic smv,
                        input bit early, output int lat, output logic [2:0] gel);
      logic [W-1:0] x;
      if (smv) begin
         if ($signed(av) > $signed(bv))      gel = 3'b100;
         else if ($signed(av) < $signed(bv)) gel = 3'b001;
         else                                gel = 3'b010;
      end else begin
         if (av > bv)      gel = 3'b100;
         else if (av < bv) gel = 3'b001;
         else              gel = 3'b010;
      end
      lat = N;
      x   = av ^ bv;
      if (early) begin
         for (int j = 0; j < N; j++) begin
            if (((x >> (W - D - j*D)) & W'(2**D - 1)) != '0) begin
               lat = j + 1;
               break;
            end
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_op(input int w, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic smv, input int elat, input logic [2:0] egel,
                         input bit rr_early, input string tag);
      int got;
      @(negedge clk);
      chk({tag, " start_ready"}, int'(sr[w]), 1);
      a = av; b = bv; sm = smv; sv[w] = 1'b1;
      @(posedge clk);
      #1;
      sv[w] = 1'b0;
      a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
      rr[w] = rr_early;
      chk({tag, " busy/ready after accept"}, int'({bz[w], sr[w]}), 2);
      got = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end else begin
            @(posedge clk);
            #1;
         end
         if (rv[w]) begin
            got = c;
            break;
         end
      end
      chk({tag, " latency"}, got, elat);
      if (got == 0) begin
         rr[w] = 1'b0;
         pulse_reset();
         return;
      end
      chk({tag, " gt/eq/lt"}, int'({o_g[w], o_e[w], o_l[w]}), int'(egel));
      rr[w] = 1'b1;
      @(posedge clk);
      #1;
      rr[w] = 1'b0;
      chk({tag, " after handshake sr/rv/flags"},
          int'({sr[w], rv[w], o_g[w], o_e[w], o_l[w]}), int'(5'b10000));
   endtask

   vec_t tbl [12];

   initial begin
      int            lat;
      logic [2:0]    gel;
      logic [W-1:0]  ra;
      logic [W-1:0]  rb;
      logic [W-1:0]  mask;
      logic          rsm;
      int            got;

      n_checks = 0;
      n_fail   = 0;
      tbl[0]  = '{16'h8000, 16'h7FFF, 1'b0, 0, 1, 3'b100};
      tbl[1]  = '{16'h8000, 16'h7FFF, 1'b1, 0, 1, 3'b001};
      tbl[2]  = '{16'h1234, 16'h1234, 1'b0, 0, 8, 3'b010};
      tbl[3]  = '{16'h1234, 16'h1234, 1'b1, 0, 8, 3'b010};
      tbl[4]  = '{16'hFFFF, 16'hFFFE, 1'b1, 0, 8, 3'b100};
      tbl[5]  = '{16'h4000, 16'h0001, 1'b0, 1, 8, 3'b100};
      tbl[6]  = '{16'h4000, 16'h0001, 1'b0, 0, 1, 3'b100};
      tbl[7]  = '{16'h0001, 16'h0002, 1'b0, 0, 8, 3'b001};
      tbl[8]  = '{16'h8000, 16'h7FFF, 1'b1, 1, 8, 3'b001};
      tbl[9]  = '{16'h0000, 16'h0000, 1'b0, 1, 8, 3'b010};
      tbl[10] = '{16'hFFFE, 16'hFFFF, 1'b1, 0, 8, 3'b001};
      tbl[11] = '{16'h0030, 16'h0010, 1'b0, 0, 6, 3'b100};

      rst_n = 1'b0;
      a = '0; b = '0; sm = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sv[i] = 1'b0;
         rr[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
         chk($sformatf("reset state dut%0d", i),
             int'({sr[i], bz[i], rv[i], o_g[i], o_e[i], o_l[i]}), int'(6'b100000));
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++)
         run_op(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].lat, tbl[i].gel,
                1'b0, $sformatf("vec%0d", i));

      // Backpressure: result held while new operands are offered.
      @(negedge clk);
      a = 16'h8000; b = 16'h7FFF; sm = 1'b0; sv[0] = 1'b1;
      @(posedge clk);
      #1 sv[0] = 1'b0;
      got = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (rv[0]) begin
            got = c;
            break;
         end
      end
      chk("bp latency", got, 1);
      for (int c = 0; c < 5; c++) begin
         sv[0] = 1'b1; a = 16'h0001; b = 16'h0002;
         chk($sformatf("bp hold %0d", c),
             int'({sr[0], rv[0], o_g[0], o_e[0], o_l[0]}), int'(5'b01100));
         @(posedge clk);
         #1;
      end
      sv[0] = 1'b0;
      chk("bp hold final", int'({sr[0], rv[0], o_g[0], o_e[0], o_l[0]}), int'(5'b01100));
      rr[0] = 1'b1;
      @(posedge clk);
      #1 rr[0] = 1'b0;
      chk("bp release", int'({sr[0], rv[0], bz[0]}), int'(3'b100));
      @(posedge clk);
      #1;
      chk("bp no stale accept", int'({sr[0], bz[0]}), int'(2'b10));

      // Reset in the middle of an equal-operand compare.
      @(negedge clk);
      a = 16'h1234; b = 16'h1234; sm = 1'b0; sv[0] = 1'b1;
      @(posedge clk);
      #1 sv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("mid-run reset state",
          int'({sr[0], bz[0], rv[0], o_g[0], o_e[0], o_l[0]}), int'(6'b100000));
      @(posedge clk);
      #1;
      chk("mid-run reset stays idle", int'({sr[0], rv[0]}), int'(2'b10));
      run_op(0, 16'h0001, 16'h0002, 1'b0, 8, 3'b001, 1'b0, "post-reset");

      for (int i = 0; i < 200; i++) begin
         ra   = W'($urandom);
         mask = W'((32'h1 << $urandom_range(0, W)) - 1);
         rb   = ($urandom_range(0, 3) == 0) ? W'($urandom) : (ra ^ (mask & W'($urandom)));
         rsm  = 1'($urandom);
         model(ra, rb, rsm, (i % 2) == 0, lat, gel);
         run_op(i % 2, ra, rb, rsm, lat, gel, 1'($urandom), $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
